xcorr_ram_ctrl: RTL and testbench

//  Address sequencer for the xcorr IQ sample RAM (write every clk at count_w, registered read at count_r, 1-clk latency).

---
 rtl/xcorr_pkg.sv | 16 +
 rtl/xcorr_ram_ctrl.sv | 159 +++++++++++++++
 tb/tb_xcorr_ram_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared types and default sizing for the xcorr IQ sample RAM sequencer.
//   xc_state_t    replay sequencer state (IDLE, READ, DRAIN)
//   XC_RM_DEP     default RAM address width (buffer depth 2**XC_RM_DEP samples)
//   XC_WIN        default replay window length in samples
package xcorr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } xc_state_t;

    localparam int unsigned XC_RM_DEP = 12;
    localparam int unsigned XC_WIN    = 1024;

endpackage

// File: rtl/xcorr_ram_ctrl.sv
// xcorr_ram_ctrl: address sequencer for the xcorr IQ sample RAM.
// The RAM (instantiated by the parent) writes every clock at o_count_w and performs a registered
// read at o_count_r with one clock of latency. Incoming samples fill the RAM as a circular buffer;
// on request the WIN most recent samples are replayed oldest first with framing strobes.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_in_valid   RAM input holds a valid sample this clock
//   i_start      replay request, level sampled each clock
//   o_count_w    RAM write address (next free slot)
//   o_count_r    RAM read address
//   o_rd_valid   RAM output belongs to the current window
//   o_rd_first   with o_rd_valid: oldest sample of the window
//   o_rd_last    with o_rd_valid: newest sample of the window
//   o_busy       replay in progress (start ignored)
//   o_done       1-clock pulse the clock after o_rd_last
//   o_start_err  1-clock pulse: start rejected because fewer than WIN samples are buffered
//   o_overrun    sticky: window may have been overwritten during replay; cleared on accept
module xcorr_ram_ctrl
    import xcorr_pkg::*;
#(
    parameter int unsigned RM_DEP = XC_RM_DEP,
    parameter int unsigned WIN    = XC_WIN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    input  logic              i_start,
    output logic [RM_DEP-1:0] o_count_w,
    output logic [RM_DEP-1:0] o_count_r,
    output logic              o_rd_valid,
    output logic              o_rd_first,
    output logic              o_rd_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_start_err,
    output logic              o_overrun
);

    localparam int unsigned DEPTH = 1 << RM_DEP;

    localparam logic [RM_DEP-1:0] WIN_ADDR  = RM_DEP'(WIN);
    localparam logic [RM_DEP-1:0] ADDR_ONE  = RM_DEP'(1);
    localparam logic [RM_DEP:0]   CNT_ONE   = (RM_DEP + 1)'(1);
    localparam logic [RM_DEP:0]   WIN_CNT   = (RM_DEP + 1)'(WIN);
    localparam logic [RM_DEP:0]   LAST_CNT  = (RM_DEP + 1)'(WIN - 1);
    localparam logic [RM_DEP:0]   DEPTH_CNT = (RM_DEP + 1)'(DEPTH);
    // Writes that can land outside the window before it has been fully read.
    localparam logic [RM_DEP:0]   OVR_LIM   = (RM_DEP + 1)'(DEPTH - WIN);

    if (WIN < 1 || WIN > DEPTH - 1) begin : g_bad_win
        $error("xcorr_ram_ctrl: WIN must be in 1..2**RM_DEP-1");
    end

    xc_state_t         r_state;
    logic [RM_DEP-1:0] r_count_w;
    logic [RM_DEP-1:0] r_count_r;
    logic [RM_DEP:0]   r_fill;
    logic [RM_DEP:0]   r_rd_cnt;
    logic [RM_DEP:0]   r_wr_cnt;
    logic              r_rd_valid;
    logic              r_rd_first;
    logic              r_rd_last;
    logic              r_busy;
    logic              r_done;
    logic              r_start_err;
    logic              r_overrun;

    logic              w_enough;
    logic [RM_DEP:0]   w_fill_nxt;
    logic [RM_DEP-1:0] w_base;
    logic              w_issue;

    assign w_enough   = (r_fill >= WIN_CNT);
    assign w_fill_nxt = (r_fill == DEPTH_CNT) ? r_fill : r_fill + CNT_ONE;
    // Pre-edge write pointer: a sample arriving in the accept clock is not part of the window.
    assign w_base     = r_count_w - WIN_ADDR;
    assign w_issue    = (r_state == READ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_count_w   <= '0;
            r_count_r   <= '0;
            r_fill      <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_first  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // The RAM writes every clock; only a valid sample advances the pointer.
            if (i_in_valid) begin
                r_count_w <= r_count_w + ADDR_ONE;
                r_fill    <= w_fill_nxt;
            end

            // Read strobes trail the address issue by the RAM read latency.
            r_rd_valid  <= w_issue;
            r_rd_first  <= w_issue && (r_rd_cnt == '0);
            r_rd_last   <= w_issue && (r_rd_cnt == LAST_CNT);
            r_done      <= 1'b0;
            r_start_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_start && w_enough) begin
                        r_count_r <= w_base;
                        r_rd_cnt  <= '0;
                        r_wr_cnt  <= '0;
                        r_overrun <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= READ;
                    end else if (i_start) begin
                        r_start_err <= 1'b1;
                    end
                end
                READ: begin
                    r_count_r <= r_count_r + ADDR_ONE;
                    r_rd_cnt  <= r_rd_cnt + CNT_ONE;
                    // Only writes while addresses are still being issued can hit an unread slot.
                    if (i_in_valid) begin
                        r_wr_cnt <= r_wr_cnt + CNT_ONE;
                        if (r_wr_cnt >= OVR_LIM) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (r_rd_cnt == LAST_CNT) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_count_w   = r_count_w;
    assign o_count_r   = r_count_r;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_first  = r_rd_first;
    assign o_rd_last   = r_rd_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_start_err = r_start_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_xcorr_ram_ctrl.sv
// Bench for xcorr_ram_ctrl: four instances (RM_DEP=4, WIN = 8, 12, 15, 1) share one stimulus
// stream, each with its own sample RAM holding the running sample index. A per-instance model
// built from sample history and replay timing predicts every output each clock.
module tb_xcorr_ram_ctrl;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] s = '0;
    logic [15:0] wdata;
    logic [NDUT-1:0] busy_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign wdata = in_valid ? s : 16'hDEAD;

    always @(posedge clk) begin
        if (rst) s <= '0;
        else if (in_valid) s <= s + 16'd1;
    end

    task automatic check(input string name, input int w, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (WIN=%0d) at %0t: got %0d, expected %0d", name, w, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 12 : (g == 2) ? 15 : 1;

        logic [3:0]  w_cw, w_cr;
        logic        w_rv, w_rf, w_rl, w_busy, w_done, w_err, w_ovr;
        logic [15:0] mem [16];
        logic [15:0] rdata;

        xcorr_ram_ctrl #(.RM_DEP(4), .WIN(W)) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_in_valid (in_valid),
            .i_start    (start),
            .o_count_w  (w_cw),
            .o_count_r  (w_cr),
            .o_rd_valid (w_rv),
            .o_rd_first (w_rf),
            .o_rd_last  (w_rl),
            .o_busy     (w_busy),
            .o_done     (w_done),
            .o_start_err(w_err),
            .o_overrun  (w_ovr)
        );

        assign busy_v[g] = w_busy;

        always @(posedge clk) begin
            mem[w_cw] <= wdata;
            rdata     <= mem[w_cr];
        end

        // Model state: history of valid samples and timing of the current replay.
        int m_cyc = 0;
        int nv = 0;
        int hist[$];
        int win[$];
        bit have_acc = 0;
        int a = 0;
        int base = 0;
        int err_cyc = -1;
        int wcnt = 0;
        bit ovr = 0;
        logic [3:0] e_cw = '0, e_cr = '0;
        bit e_rv = 0, e_rf = 0, e_rl = 0, e_busy = 0, e_done = 0, e_err = 0, e_ovr = 0;
        int e_data = 0;

        // Observations used by the directed literal checks.
        int first_data = -1, last_data = -1, gap = -1, last_done = -100;
        int n_first = 0, n_err = 0;

        always @(posedge clk) begin
            m_cyc++;
            if (rst) begin
                nv = 0; hist.delete(); win.delete(); have_acc = 0; err_cyc = -1; ovr = 0;
                wcnt = 0; e_cw = '0; e_cr = '0; e_rv = 0; e_rf = 0; e_rl = 0; e_busy = 0;
                e_done = 0; e_err = 0; e_ovr = 0; e_data = 0;
            end else begin
                bit idle;
                int off;
                int addr;
                idle = !(have_acc && (m_cyc - 1) >= a && (m_cyc - 1) <= a + W);
                if (idle && start) begin
                    if (hist.size() >= W) begin
                        have_acc = 1; a = m_cyc; base = nv; wcnt = 0; ovr = 0;
                        win.delete();
                        for (int k = 0; k < W; k++) win.push_back(hist[hist.size() - W + k]);
                    end else begin
                        err_cyc = m_cyc;
                    end
                end
                if (in_valid) begin
                    hist.push_back(int'(s));
                    if (hist.size() > 16) void'(hist.pop_front());
                    nv++;
                    if (have_acc && m_cyc >= a + 1 && m_cyc <= a + W) begin
                        wcnt++;
                        if (wcnt > 16 - W) ovr = 1;
                    end
                end
                e_cw   = nv[3:0];
                e_busy = have_acc && m_cyc >= a && m_cyc <= a + W;
                e_rv   = have_acc && m_cyc >= a + 1 && m_cyc <= a + W;
                e_rf   = have_acc && m_cyc == a + 1;
                e_rl   = have_acc && m_cyc == a + W;
                e_done = have_acc && m_cyc == a + W + 1;
                e_err  = (err_cyc == m_cyc);
                e_ovr  = ovr;
                off    = (m_cyc - a < W) ? m_cyc - a : W;
                addr   = base - W + off;
                e_cr   = have_acc ? addr[3:0] : 4'd0;
                e_data = e_rv ? win[m_cyc - a - 1] : 0;
            end
        end

        always @(negedge clk) begin
            if (m_cyc > 0) begin
                check("count_w",   W, 32'(w_cw),   32'(e_cw));
                check("count_r",   W, 32'(w_cr),   32'(e_cr));
                check("rd_valid",  W, 32'(w_rv),   32'(e_rv));
                check("rd_first",  W, 32'(w_rf),   32'(e_rf));
                check("rd_last",   W, 32'(w_rl),   32'(e_rl));
                check("busy",      W, 32'(w_busy), 32'(e_busy));
                check("done",      W, 32'(w_done), 32'(e_done));
                check("start_err", W, 32'(w_err),  32'(e_err));
                check("overrun",   W, 32'(w_ovr),  32'(e_ovr));
                if (e_rv && !e_ovr) check("rd_data", W, 32'(rdata), 32'(e_data));
                if (w_done) last_done = m_cyc;
                if (w_rv && w_rf) begin
                    first_data = int'(rdata);
                    gap = m_cyc - last_done;
                    n_first++;
                end
                if (w_rv && w_rl) last_data = int'(rdata);
                if (w_err) n_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n);
        in_valid = 1'b1;
        repeat (n) tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy_v == '0) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_idle: busy still %b after 300 clocks, expected 0", busy_v);
        end
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        int e0, f0, cnt;
        bit hit;
        repeat (3) tick();
        rst = 1'b0;

        // 20 samples then a replay: newest 8 are 12..19, newest 15 are 5..19.
        push(20);
        pulse_start();
        wait_idle();
        check("t1_first", 8, 32'(g_dut[0].first_data), 32'd12);
        check("t1_last", 8, 32'(g_dut[0].last_data), 32'd19);
        check("t1_first", 15, 32'(g_dut[2].first_data), 32'd5);
        check("t1_last", 15, 32'(g_dut[2].last_data), 32'd19);

        // Too few samples: rejected; three more make a full window of 0..7.
        do_reset();
        e0 = g_dut[0].n_err;
        push(5);
        pulse_start();
        check("t2_busy", 8, 32'(g_dut[0].w_busy), 32'd0);
        tick();
        check("t2_err_cnt", 8, 32'(g_dut[0].n_err), 32'(e0 + 1));
        wait_idle();
        push(3);
        pulse_start();
        wait_idle();
        check("t2_first", 8, 32'(g_dut[0].first_data), 32'd0);
        check("t2_last", 8, 32'(g_dut[0].last_data), 32'd7);

        // Continuous writes during replay: fine for WIN=8, overrun for WIN=12.
        push(8);
        in_valid = 1'b1;
        pulse_start();
        wait_idle();
        in_valid = 1'b0;
        check("t3_ovr", 8, 32'(g_dut[0].w_ovr), 32'd0);
        check("t3_ovr", 12, 32'(g_dut[1].w_ovr), 32'd1);
        check("t3_first", 8, 32'(g_dut[0].first_data), 32'd8);
        check("t3_last", 8, 32'(g_dut[0].last_data), 32'd15);

        // Wrap: 100 samples into depth 16.
        do_reset();
        push(100);
        pulse_start();
        wait_idle();
        check("t4_first", 15, 32'(g_dut[2].first_data), 32'd85);
        check("t4_last", 15, 32'(g_dut[2].last_data), 32'd99);
        check("t4_first", 8, 32'(g_dut[0].first_data), 32'd92);

        // start held high: back-to-back replays, second accepted in the done clock.
        f0 = g_dut[0].n_first;
        start = 1'b1;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (g_dut[0].n_first >= f0 + 2) begin
                hit = 1;
                break;
            end
        end
        start = 1'b0;
        check("t5_two_replays", 8, 32'(hit), 32'd1);
        wait_idle();
        check("t5_gap", 8, 32'(g_dut[0].gap), 32'd2);

        // start pulses while busy are ignored.
        f0 = g_dut[0].n_first;
        pulse_start();
        tick();
        pulse_start();
        tick();
        pulse_start();
        wait_idle();
        check("t5_one_replay", 8, 32'(g_dut[0].n_first), 32'(f0 + 1));

        // Reset at the 3rd rd_valid aborts; fill is cleared so the next start is rejected.
        pulse_start();
        cnt = 0;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (g_dut[0].w_rv) cnt++;
            if (cnt == 3) begin
                hit = 1;
                break;
            end
            tick();
        end
        check("t6_third_rv", 8, 32'(hit), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 8, 32'(g_dut[0].w_busy), 32'd0);
        check("t6_rv", 8, 32'(g_dut[0].w_rv), 32'd0);
        check("t6_cw", 8, 32'(g_dut[0].w_cw), 32'd0);
        e0 = g_dut[0].n_err;
        pulse_start();
        tick();
        check("t6_err_cnt", 8, 32'(g_dut[0].n_err), 32'(e0 + 1));

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            start    = ($urandom_range(0, 9) == 0);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
